// File: rtl/ram_stream_reader_if.sv
// Valid/ready word stream carrying RAM read data from ram_stream_reader to
// the downstream compute stage.
interface ram_stream_reader_if #(
  parameter int WIDTH = 32
);
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_last;
  logic             m_ready;

  modport master (output m_valid, m_data, m_last, input m_ready);
  modport slave  (input m_valid, m_data, m_last, output m_ready);
endinterface

// File: rtl/ram_stream_reader.sv
// Sweeps a contiguous range of a 1-cycle-latency RAM and streams the words
// out through a 2-entry skid buffer with valid/ready backpressure.
//
// state  | meaning
// IDLE   | waiting for start; job arguments latched on start
// RUN    | issuing reads and draining the output buffer
// FINISH | one-cycle done pulse, then back to IDLE
module ram_stream_reader #(
  parameter int  WIDTH = 32,
  parameter int  DEPTH = 5408,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [CW-1:0]    count,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    ram_addr,
  input  logic [WIDTH-1:0] ram_dout,
  ram_stream_reader_if.master m
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    issue_left;
  logic [CW-1:0]    beat_left;
  logic             inflight;
  logic [1:0]       occ;
  logic             wr_sel, rd_sel;
  logic [WIDTH-1:0] buf_q [2];
  logic             accept, issue, pop;
  logic [2:0]       fill;

  assign pop        = m.m_valid & m.m_ready;
  assign m.m_valid  = (occ != 2'd0);
  assign m.m_data   = buf_q[rd_sel];
  assign m.m_last   = m.m_valid & (beat_left == CW'(1));
  assign ram_addr   = rd_ptr;
  assign fill       = {1'b0, occ} + {2'b00, inflight};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    issue   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = (count == '0) ? S_FINISH : S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        // Words already buffered plus the one returning from RAM must leave
        // room for this read once this cycle's pop (if any) is accounted for.
        issue = (issue_left != '0) && (fill < (3'd2 + {2'b00, pop}));
        if (pop && (beat_left == CW'(1))) state_d = S_FINISH;
      end
      S_FINISH: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      issue_left <= '0;
      beat_left  <= '0;
      inflight   <= 1'b0;
      occ        <= 2'd0;
      wr_sel     <= 1'b0;
      rd_sel     <= 1'b0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
    end else begin
      inflight <= issue;
      if (accept) begin
        rd_ptr     <= base_addr;
        issue_left <= count;
        beat_left  <= count;
      end else begin
        if (issue) begin
          rd_ptr     <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
          issue_left <= issue_left - CW'(1);
        end
        if (pop) beat_left <= beat_left - CW'(1);
      end
      if (inflight) begin
        buf_q[wr_sel] <= ram_dout;
        wr_sel        <= ~wr_sel;
      end
      if (pop) rd_sel <= ~rd_sel;
      occ <= occ + {1'b0, inflight} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Scoreboard bench for ram_stream_reader: jobs push expected beats into a
// queue, a negedge monitor compares every presented word against the queue.
module tb_ram_stream_reader;
  localparam int WIDTH = 32;
  localparam int DEPTH = 5408;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [AW-1:0]    base_addr = '0;
  logic [CW-1:0]    count = '0;
  logic             busy, done;
  logic [AW-1:0]    ram_addr;
  logic [WIDTH-1:0] ram_dout = '0;

  ram_stream_reader_if #(.WIDTH(WIDTH)) s_if ();

  ram_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .ram_addr  (ram_addr),
    .ram_dout  (ram_dout),
    .m         (s_if.master)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clk) ram_dout <= (int'(ram_addr) < DEPTH) ? mem[ram_addr] : '0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_t;
  beat_t exp_q[$];

  int checks = 0, errors = 0;
  int beats = 0, done_cnt = 0, done_cyc = -1, first_valid_cyc = -1;
  int start_c = 0, done0 = 0, beats0 = 0;
  bit bp_mode = 1'b0;

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (s_if.m_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (exp_q.size() == 0) check("unexpected_beat", s_if.m_valid, 0);
        else begin
          check("m_data", s_if.m_data, exp_q[0].data);
          check("m_last", s_if.m_last, exp_q[0].last);
          if (s_if.m_ready) begin
            void'(exp_q.pop_front());
            beats++;
          end
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("busy_in_done_cycle", busy, 0);
      end
    end
  end

  // Consumer backpressure: fixed opening pattern, then random.
  initial begin
    int idx = 0;
    logic [5:0] pat = 6'b101001;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) begin
        if (idx < 6) s_if.m_ready = pat[idx];
        else         s_if.m_ready = 1'($urandom_range(0, 1));
        idx++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(int b, int n);
    for (int i = 0; i < n; i++) begin
      beat_t e;
      e.data = WIDTH'(((b + i) % DEPTH) + 100);
      e.last = (i == n - 1);
      exp_q.push_back(e);
    end
    first_valid_cyc = -1;
    done0     = done_cnt;
    beats0    = beats;
    base_addr = AW'(b);
    count     = CW'(n);
    start     = 1'b1;
    start_c   = cyc;
    tick();
    start = 1'b0;
    @(negedge clk);
    if (n > 0) begin
      check("busy_after_start", busy, 1);
      check("first_ram_addr", ram_addr, b);
    end else begin
      check("zero_len_done", done, 1);
      check("zero_len_busy", busy, 0);
    end
  endtask

  task automatic finish_job(int n, int exp_first, int exp_done, int limit);
    bit got = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (done_cnt > done0) begin
        got = 1'b1;
        break;
      end
    end
    check("done_seen", got, 1);
    if (got && exp_done >= 0) check("done_latency", done_cyc - start_c, exp_done);
    if (exp_first >= 0) check("first_valid_latency", first_valid_cyc - start_c, exp_first);
    if (n == 0) check("zero_len_no_valid", first_valid_cyc, -1);
    check("beat_count", beats - beats0, n);
    check("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(i + 100);
    s_if.m_ready = 1'b1;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_m_valid", s_if.m_valid, 0);
    check("rst_m_last", s_if.m_last, 0);
    check("rst_m_data", s_if.m_data, 0);
    check("rst_ram_addr", ram_addr, 0);
    rst = 1'b0;
    tick();

    // Basic
    launch(0, 4);
    finish_job(4, 3, 7, 100);

    // Wrap across DEPTH-1 -> 0
    launch(5406, 4);
    finish_job(4, 3, 7, 100);

    // Backpressure
    bp_mode = 1'b1;
    launch(200, 8);
    finish_job(8, -1, -1, 300);
    bp_mode = 1'b0;
    s_if.m_ready = 1'b1;
    tick();

    // Zero length
    launch(7, 0);
    finish_job(0, -1, 1, 20);

    // Start during a running job is ignored
    launch(300, 16);
    tick();
    base_addr = AW'(50);
    count     = CW'(3);
    start     = 1'b1;
    tick();
    start = 1'b0;
    finish_job(16, 3, 19, 100);

    // Reset in the middle of a job
    launch(1000, 20);
    for (int i = 0; i < 60 && (beats - beats0) < 5; i++) @(negedge clk);
    check("beats_before_reset", beats - beats0, 5);
    #2 rst = 1'b1;
    #1;
    check("midrst_m_valid", s_if.m_valid, 0);
    check("midrst_m_data", s_if.m_data, 0);
    check("midrst_m_last", s_if.m_last, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_ram_addr", ram_addr, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    launch(10, 2);
    finish_job(2, 3, 5, 50);

    // Full sweep
    launch(100, DEPTH);
    finish_job(DEPTH, 3, DEPTH + 3, DEPTH + 100);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_stream_reader.md
# ram_stream_reader

Read-side streaming engine for the accelerator's single-port feature-map RAM (1-cycle registered read, `dout` updates every clock from `addr`). On a start pulse it sweeps a contiguous address range, absorbs the RAM read latency, and presents the words as a valid/ready stream with backpressure. It sits between a feature-map RAM and the next compute stage (conv/pool input), and drives the RAM address port while busy.

## Interface

- `WIDTH`, 32, data word width; must match the RAM.
- `DEPTH`, 5408, RAM depth in words; address width `AW = $clog2(DEPTH)`, count width `CW = $clog2(DEPTH+1)`.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `base_addr`  in  AW  first address, sampled with `start`; must be < DEPTH.
- `count`  in  CW  number of words, sampled with `start`; 0..DEPTH.
- `busy`  out  1  high from the cycle after accepted `start` until `done`.
- `done`  out  1  one-cycle pulse at job end.
- `ram_addr`  out  AW  to RAM `addr`.
- `ram_dout`  in  WIDTH  from RAM `dout`.
- `m_valid`  out  1  output word valid.
- `m_data`  out  WIDTH  output word.
- `m_last`  out  1  marks final word of the job; qualified by `m_valid`.
- `m_ready`  in  1  consumer accepts when `m_valid & m_ready`.

## Operation

- States: IDLE, RUN, FINISH.
- IDLE: `start` → latch `rd_ptr = base_addr`, `issue_left = count`, `beat_left = count`; go RUN. `start` with `count == 0` → go FINISH directly (no beats).
- RUN issue rule: a read issues in a cycle when `issue_left != 0` and `occ + inflight - pop < 2`, where `occ` = entries in 2-deep output buffer, `inflight` = reads issued last cycle (0/1), `pop` = handshake this cycle. On issue: `ram_addr = rd_ptr`; `rd_ptr` increments, wrapping DEPTH-1 → 0; `issue_left` decrements.
- `ram_addr` is driven combinationally from `rd_ptr`; it holds its value when not issuing.
- Cycle after an issue: `ram_dout` written into the output buffer (buffer can never overflow by the issue rule).
- Output: `m_valid = (occ != 0)`, `m_data` = buffer head; `m_last = m_valid & (beat_left == 1)`. On handshake, pop head and decrement `beat_left`.
- RUN → FINISH on the handshake that takes `beat_left` from 1 to 0.
- FINISH: `done = 1` for exactly one cycle, `busy = 0`; return to IDLE. New `start` accepted from IDLE (next cycle).
- `start` while not in IDLE: ignored, no effect on the running job.
- `m_data`/`m_valid` stable while `m_valid & ~m_ready` (standard stall rule).
- No writes: block never drives RAM `we`; owner ties RAM `we` low or arbitrates.

## Timing

- Reset (async, any state, including mid-job): state IDLE, `busy=0`, `done=0`, `m_valid=0`, `m_last=0`, `m_data=0`, `ram_addr=0`, buffer and `inflight` cleared; in-flight RAM data discarded.
- Start latency: `start` sampled at edge E0; `busy=1` and first issue in cycle after E0; word written into buffer at E2; `m_valid=1` in cycle after E2 (3 cycles after `start`).
- Throughput: 1 word/cycle with `m_ready` held high; no bubbles after the first word.
- Backpressure: `m_ready` low for N cycles stops issues within one cycle; at most 2 words buffered; resumes at full rate next cycle after `m_ready` returns.
- `done` pulses in the cycle after the final handshake; `busy` falls in the same cycle as `done`.
- `count == 0`: `done` in cycle after E0, `busy` never asserted, no `m_valid`.
- `count == DEPTH`: full sweep, each address read exactly once with wrap.

## Test plan

- Basic: `base_addr=0`, `count=4`, RAM preloaded `mem[i]=i+100`, `m_ready=1` → beats 100,101,102,103 on consecutive cycles, first `m_valid` 3 cycles after start, `m_last` on 103, `done` 1 cycle later.
- Wrap: `base_addr=5406`, `count=4` → `ram_addr` sequence 5406,5407,0,1; data in that order; `m_last` on 4th beat.
- Backpressure: `count=8`, `m_ready` toggling 1,0,0,1,0,1… random → all 8 words in order, none dropped/duplicated, `m_data` stable during stalls, never more than 2 issues ahead of pops.
- Zero length and ignored start: `count=0` → `done` pulse next cycle, no beats; during a `count=16` job, pulse `start` with other args → job unaffected, exactly 16 beats.
- Reset mid-job: assert `rst` after 5 of 20 beats → outputs to reset values immediately; new job `base_addr=10,count=2` afterwards returns `mem[10], mem[11]` only.
- Full sweep: `count=5408`, `base_addr=100`, `m_ready=1` → 5408 beats, each address once, total 5408+3 cycles start-to-`done`-ish (last beat at cycle 5410, `done` at 5411).
